// File: rtl/subtrator_pipe.sv
// Two-stage add/subtract pipeline with valid/ready handshake.
// Stage 1 forms the raw WIDTH+1 bit sum/difference, stage 2 converts it to sign-magnitude.
module subtrator_pipe #(
  parameter int         WIDTH  = 4,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [WIDTH:0]   out,
  output logic             err
);

  typedef struct packed {
    logic           sub;
    logic           bad;
    logic [WIDTH:0] raw;
  } s1_t;

  s1_t          s1_q, s1_d;
  logic [2:1]   vld_pipe;
  logic         accept, adv;
  logic         s2_s, s2_err;
  logic [WIDTH:0] s2_out;

  assign in_ready  = !vld_pipe[1] | !vld_pipe[2] | out_ready;
  assign accept    = in_valid & in_ready;
  assign adv       = vld_pipe[1] & (!vld_pipe[2] | out_ready);
  assign out_valid = vld_pipe[2];

  always_comb begin
    s1_d     = '0;
    s1_d.sub = (op == OP_SUB);
    s1_d.bad = !((op == OP_ADD) || (op == OP_SUB));
    if (op == OP_ADD)      s1_d.raw = {1'b0, a} + {1'b0, b};
    else if (op == OP_SUB) s1_d.raw = {1'b0, a} - {1'b0, b};
  end

  // Only a subtraction can go negative; for addition the top bit is carry.
  // A negative raw value is never zero, so negative zero cannot arise.
  always_comb begin
    s2_s   = 1'b0;
    s2_out = s1_q.raw;
    s2_err = s1_q.bad;
    if (s1_q.bad) begin
      s2_out = '0;
    end else if (s1_q.sub && s1_q.raw[WIDTH]) begin
      s2_s   = 1'b1;
      s2_out = -s1_q.raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s        <= 1'b0;
      out      <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe[1] <= accept | (vld_pipe[1] & !adv);
      if (accept) s1_q <= s1_d;
      if (adv) begin
        vld_pipe[2] <= 1'b1;
        s           <= s2_s;
        out         <= s2_out;
        err         <= s2_err;
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/subtrator_pipe.md
SUBTRATOR_PIPE -- requirements
Module: subtrator_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..32).
REQ-002 SHALL have parameter OP_ADD, default 4'b0001, opcode selecting addition.
REQ-003 SHALL have parameter OP_SUB, default 4'b0010, opcode selecting subtraction.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream presents a, b, op.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-009 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-010 SHALL have port op  input  4  operation code.
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port s  output  1  result sign (1 = negative).
REQ-014 SHALL have port out  output  WIDTH+1  result magnitude.
REQ-015 SHALL have port err  output  1  op matched neither OP_ADD nor OP_SUB.

Function
REQ-016 SHALL accept a transaction on any rising edge where in_valid and in_ready are both 1.
REQ-017 SHALL implement two registered stages: S1 computes raw = {0,a} + {0,b} or {0,a} - {0,b} (WIDTH+1 bits); S2 converts raw to sign-magnitude.
REQ-018 SHALL present the result with out_valid=1 exactly 2 cycles after acceptance when out_ready stays 1; throughput 1 transaction/cycle.
REQ-019 SHALL, for OP_SUB, set s = (a < b) unsigned and out = |a - b| zero-extended to WIDTH+1 bits.
REQ-020 SHALL, for OP_ADD, set s = 0 and out = a + b including carry in bit WIDTH.
REQ-021 SHALL, for any other op, set s = 0, out = 0, err = 1; err = 0 for legal ops.
REQ-022 SHALL derive s, out and err of one result from the same accepted transaction (no mixing with prior/next operands).
REQ-023 SHALL never output negative zero: a == b under OP_SUB gives s = 0, out = 0.
REQ-024 SHALL advance S1->S2 when S2 is empty or out_ready = 1; S2 empties when out_valid and out_ready both 1.
REQ-025 SHALL drive in_ready = !v1 | !v2 | out_ready, where v1/v2 are stage valid flags (combinational, no dependence on in_valid).
REQ-026 SHALL hold s, out, err, out_valid stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL deliver results in acceptance order, none dropped or duplicated, with at most 2 in flight.
REQ-028 SHALL ignore a, b, op when in_valid = 0 or in_ready = 0.

Reset
REQ-029 SHALL, on rising edge with rst = 1, clear v1, v2, out_valid, s, out, err to 0, discarding in-flight transactions.
REQ-030 SHALL drive in_ready = 1 in the cycle after reset deasserts; inputs presented while rst = 1 are not accepted.
REQ-031 SHALL give rst priority over simultaneous acceptance or output handshake in the same cycle.

Verification (WIDTH = 4)
REQ-032 SHALL pass: a=3, b=5, op=0010, out_ready=1 -> 2 cycles later out_valid=1, s=1, out=5'd2, err=0.
REQ-033 SHALL pass: a=15, b=15, op=0001 -> s=0, out=5'd30; then a=0, b=15, op=0010 next cycle -> s=1, out=5'd15 one cycle later.
REQ-034 SHALL pass: a=7, b=7, op=0010 -> s=0, out=0 (no negative zero).
REQ-035 SHALL pass: three back-to-back transactions (9-4, 2-8, 6+6) with out_ready=0 for 4 cycles -> in_ready=0 after two accepted, third held upstream, outputs frozen at s=0/out=5; after out_ready=1 results 5, -6 (s=1,out=6), 12 emerge in order on consecutive cycles.
REQ-036 SHALL pass: op=0111, a=3, b=1 -> s=0, out=0, err=1.
REQ-037 SHALL pass: rst=1 for one cycle with 2 transactions in flight -> next cycle out_valid=0, out=0, in_ready=1, and no stale result ever appears.
